// File: rtl/alu32_byte_serial_addsub_pkg.sv
// Shared definitions for the byte-serial add/subtract unit: FSM states, opcodes,
// saturation constants and the signed-overflow helper.
package alu32_byte_serial_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG = 32'h8000_0000;

  // Operands share a sign that the result does not carry.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu32_byte_serial_addsub_if.sv
// Operand/result handshake bundle for the byte-serial add/subtract unit.
// master = operand source and result sink, slave = the arithmetic unit.
interface alu32_byte_serial_addsub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, carry, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, carry, overflow, zero
  );
endinterface

// File: rtl/alu32_byte_serial_addsub_adder_8.sv
// adder_8: 8-bit carry-lookahead slice, time-multiplexed by the byte-serial unit.
module adder_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    // Flattened generate/propagate chain; synthesis collapses it to lookahead form.
    for (int unsigned i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    s    = p ^ c[7:0];
    cout = c[8];
  end
endmodule

// File: rtl/alu32_byte_serial_addsub.sv
// alu32_byte_serial_addsub: multi-cycle add/subtract, one 8-bit slice per cycle.
// Optional build macro: ALU_ADDSUB_SAT_EN (saturate result on signed overflow).
module alu32_byte_serial_addsub
  import alu32_byte_serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  alu32_byte_serial_addsub_if.slave   bus
);
  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned MSB    = WIDTH - 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [WIDTH-1:0] res_asm, res_fin;
  logic [KW-1:0]    k;
  logic             carry_reg, carry_q, ovf_q, zero_q;
  logic [SLICE-1:0] s;
  logic             cout;
  logic             accept, last, ovf_raw;

  adder_8 u_slice (
    .a    (a_q[k*SLICE +: SLICE]),
    .b    (b_q[k*SLICE +: SLICE]),
    .cin  (carry_reg),
    .s    (s),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    bus.out_valid = 1'b0;
    accept       = 1'b0;
    last         = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        accept       = bus.in_valid;
        if (bus.in_valid) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        last = (k == K_LAST);
        if (k == K_LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Flags come from the fully assembled word, including the slice being written this edge.
  always_comb begin
    res_asm                    = result_q;
    res_asm[k*SLICE +: SLICE]  = s;
    ovf_raw                    = signed_ovf(a_q[MSB], b_q[MSB], res_asm[MSB]);
    res_fin                    = res_asm;
`ifdef ALU_ADDSUB_SAT_EN
    if (ovf_raw) begin
      res_fin = a_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      k         <= '0;
      carry_reg <= 1'b0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else if (accept) begin
      a_q       <= bus.a;
      b_q       <= (bus.sub == ALU_OP_SUB) ? ~bus.b : bus.b;
      carry_reg <= bus.sub;
      k         <= '0;
    end else if (state == ST_BUSY) begin
      carry_reg <= cout;
      if (last) begin
        result_q <= res_fin;
        carry_q  <= cout;
        ovf_q    <= ovf_raw;
        zero_q   <= (res_fin == '0);
        k        <= '0;
      end else begin
        result_q <= res_asm;
        k        <= k + 1'b1;
      end
    end
  end

  assign bus.result   = result_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
endmodule

// File: tb/tb_alu32_byte_serial_addsub.sv
// Self-checking bench for alu32_byte_serial_addsub: directed steps plus a few
// random operations, expected results queued at accept and checked on completion.
module tb_alu32_byte_serial_addsub;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu32_byte_serial_addsub_if #(.WIDTH(32)) bus ();

  alu32_byte_serial_addsub #(.WIDTH(32), .SLICE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] be;
    logic [32:0] sum;
    exp_t e;
    be  = s ? ~b : b;
    sum = {1'b0, a} + {1'b0, be} + {32'd0, s};
    e.r = sum[31:0];
    e.c = sum[32];
    e.v = (a[31] == be[31]) && (sum[31] != a[31]);
`ifdef ALU_ADDSUB_SAT_EN
    if (e.v) e.r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input exp_t e);
    logic acc;
    acc          = 1'b0;
    bus.a        = a;
    bus.b        = b;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (bus.in_ready === 1'b1) acc = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.sub      = ~s;
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL accept_timeout observed=%b expected=1", acc);
    end
    if (acc) sb.push_back(e);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    assert (bus.out_valid === 1'b1) else begin
      errors++;
      $error("FAIL out_valid_timeout observed=%b expected=1", bus.out_valid);
    end
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb_empty observed=%0d expected>0", tag, sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_result"},   bus.result,          e.r);
      chk({tag, "_carry"},    {31'd0, bus.carry},    {31'd0, e.c});
      chk({tag, "_overflow"}, {31'd0, bus.overflow}, {31'd0, e.v});
      chk({tag, "_zero"},     {31'd0, bus.zero},     {31'd0, e.z});
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic s, input exp_t e);
    int n;
    send(a, b, s, e);
    wait_valid(n);
    chk({tag, "_latency_edges"}, 32'(n + 1), 32'd5);
    compare_pop(tag);
    release_result();
  endtask

  initial begin
    int   n;
    exp_t e2;
    logic [31:0] ra, rb;
    logic rs;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_result",    bus.result,             32'd0);
    chk("rst_flags",     {29'd0, bus.carry, bus.overflow, bus.zero}, 32'd0);

    run("t1_ff_plus_1", 32'h0000_00FF, 32'd1, 1'b0, '{32'h0000_0100, 1'b0, 1'b0, 1'b0});
`ifdef ALU_ADDSUB_SAT_EN
    run("t2_pos_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
    run("t2b_neg_ovf", 32'h8000_0000, 32'd1, 1'b1, '{32'h8000_0000, 1'b1, 1'b1, 1'b0});
`else
    run("t2_pos_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0});
    run("t2b_neg_ovf", 32'h8000_0000, 32'd1, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
`endif
    run("t3_5_minus_5", 32'd5, 32'd5, 1'b1, '{32'd0, 1'b1, 1'b0, 1'b1});
    run("t3_0_minus_1", 32'd0, 32'd1, 1'b1, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});

    // Wrap to zero, then hold the result with out_ready low and in_valid pushing.
    send(32'hFFFF_FFFF, 32'd1, 1'b0, '{32'd0, 1'b1, 1'b0, 1'b1});
    wait_valid(n);
    bus.in_valid = 1'b1;
    bus.a        = 32'h1111_1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("t4_hold_in_ready",  {31'd0, bus.in_ready},  32'd0);
      chk("t4_hold_result",    bus.result,             32'd0);
      chk("t4_hold_flags",     {29'd0, bus.carry, bus.overflow, bus.zero}, 32'd5);
    end
    bus.in_valid = 1'b0;
    compare_pop("t4_wrap");
    release_result();

    // Reset while BUSY with k=2 discards the operation.
    send(32'h1234_5678, 32'h0101_0101, 1'b0, '{32'h1335_5779, 1'b0, 1'b0, 1'b0});
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    void'(sb.pop_back());
    chk("t5_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t5_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("t5_rst_result",    bus.result,             32'd0);
    chk("t5_rst_flags",     {29'd0, bus.carry, bus.overflow, bus.zero}, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("t5_no_partial_valid", {31'd0, bus.out_valid}, 32'd0);
    run("t5_3_plus_4", 32'd3, 32'd4, 1'b0, '{32'd7, 1'b0, 1'b0, 1'b0});

    // Back-to-back: next op presented while DONE, accepted only after IDLE return.
    send(32'd10, 32'd20, 1'b0, '{32'd30, 1'b0, 1'b0, 1'b0});
    wait_valid(n);
    compare_pop("t6_first");
    bus.a         = 32'd100;
    bus.b         = 32'd40;
    bus.sub       = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    chk("t6_done_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.out_ready = 1'b0;
    chk("t6_idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t6_idle_in_ready",  {31'd0, bus.in_ready},  32'd1);
    tick();
    chk("t6_busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;
    e2 = '{32'd60, 1'b1, 1'b0, 1'b0};
    sb.push_back(e2);
    wait_valid(n);
    chk("t6_second_latency_edges", 32'(n + 1), 32'd5);
    compare_pop("t6_second");
    release_result();

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i == 0) rb = ra;
      run("rand", ra, rb, rs, model(ra, rb, rs));
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
